// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-256 block/length widths and message_strip FSM state type
// BLOCK_W  padded block width in bits
// LEN_W    width of the trailing big-endian length field
// OFF_W    width of a bit offset within one block (L mod BLOCK_W)
package sha2_pkg;
    localparam int BLOCK_W = 512;
    localparam int LEN_W = 64;
    localparam int OFF_W = 9;
    typedef enum logic [1:0] {S_EMPTY, S_HELD, S_DRAIN, S_SIZE} state_t;
endpackage

// File: rtl/message_strip_if.sv
// message_strip_if: padded-block input stream, recovered-block output stream and size report
// data_in/_last/_valid/_ready              padded block stream into the stripper
// data_out/_last/_valid/_ready             recovered data block stream
// size_out/size_err/size_valid/size_ready  message length L in bits and padding verdict
// master: stream producer/consumer side, slave: message_strip side
interface message_strip_if;
    import sha2_pkg::*;
    logic [BLOCK_W-1:0] data_in;
    logic               data_in_last;
    logic               data_in_valid;
    logic               data_in_ready;
    logic [BLOCK_W-1:0] data_out;
    logic               data_out_last;
    logic               data_out_valid;
    logic               data_out_ready;
    logic [LEN_W-1:0]   size_out;
    logic               size_err;
    logic               size_valid;
    logic               size_ready;
    modport master (
        output data_in, data_in_last, data_in_valid, data_out_ready, size_ready,
        input  data_in_ready, data_out, data_out_last, data_out_valid, size_out, size_err, size_valid
    );
    modport slave (
        input  data_in, data_in_last, data_in_valid, data_out_ready, size_ready,
        output data_in_ready, data_out, data_out_last, data_out_valid, size_out, size_err, size_valid
    );
endinterface

// File: rtl/msg_tail_check.sv
// msg_tail_check: marker/fill validation and data trim mask for the block holding bit L mod 512
// blk_i    block under test, bit 511 = first bit
// r_i      L mod 512, offset of the marker inside the block
// in_f_i   block is the final padded block, so its low LEN_W bits hold the length
// mask_o   ones over the r_i leading data bits; all ones for r_i == 0 (a full data block)
// pad_ok_o marker set, fill clear, marker clear of the length field
module msg_tail_check
    import sha2_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk_i,
    input  logic [OFF_W-1:0]   r_i,
    input  logic               in_f_i,
    output logic [BLOCK_W-1:0] mask_o,
    output logic               pad_ok_o
);
    logic [BLOCK_W-1:0] below;
    logic [BLOCK_W-1:0] fill;
    always_comb begin
        below = {BLOCK_W{1'b1}} >> ({1'b0, r_i} + (OFF_W+1)'(1));
        fill = in_f_i ? below & {{(BLOCK_W-LEN_W){1'b1}}, {LEN_W{1'b0}}} : below;
        mask_o = (r_i == '0) ? '1 : ~({BLOCK_W{1'b1}} >> r_i);
        pad_ok_o = blk_i[OFF_W'(BLOCK_W-1) - r_i] && ((blk_i & fill) == '0)
                   && !(in_f_i && r_i >= OFF_W'(BLOCK_W-LEN_W));
    end
endmodule

// File: rtl/message_strip.sv
// message_strip: strips SHA-256 padding from 512-bit blocks, recovers the data blocks and reports L
// clk    clock
// nrst   asynchronous active-low reset
// bus    message_strip_if.slave: padded input stream, data output stream, size report
// CNT_W  block counter width; a message of more than 2^CNT_W-1 blocks reports size_err
// MESSAGE_STRIP_MASK_EN: when defined, marker and fill of the final data block are zeroed on output
module message_strip
    import sha2_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic            clk,
    input logic            nrst,
    message_strip_if.slave bus
);
`ifdef MESSAGE_STRIP_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif
    state_t state_q, state_d, fin;
    logic alive_q;
    logic [BLOCK_W-1:0] h_q, h_d, out_q, out_d, sel, mask, tail_blk;
    logic out_last_q, out_last_d, out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
    logic ovf_q, ovf_d, err_q, err_d;
    logic [LEN_W-1:0] size_q, size_d, len, d_blk;
    logic [OFF_W-1:0] r;
    logic in_ready, out_free, acc, d_eq_n, d_eq_nm1, in_f, pad_ok, ok;
    assign len = bus.data_in[LEN_W-1:0];
    assign r = len[OFF_W-1:0];
    assign d_blk = {{OFF_W{1'b0}}, len[LEN_W-1:OFF_W]} + LEN_W'(|r);
    assign cnt_n = cnt_q + CNT_W'(1);
    assign d_eq_n = d_blk == LEN_W'(cnt_n);
    assign d_eq_nm1 = d_blk == LEN_W'(cnt_q);
    // The marker sits in F unless the last data block is H with a partial tail
    assign in_f = d_eq_n || r == '0;
    assign sel = in_f ? bus.data_in : h_q;
    msg_tail_check u_tail (
        .blk_i   (sel),
        .r_i     (r),
        .in_f_i  (in_f),
        .mask_o  (mask),
        .pad_ok_o(pad_ok)
    );
    assign tail_blk = MASK_EN ? sel & mask : sel;
    assign ok = pad_ok && (d_eq_n || d_eq_nm1) && !ovf_q && !(&cnt_q);
    assign out_free = !out_valid_q || bus.data_out_ready;
    assign acc = bus.data_in_valid && in_ready;
    assign bus.data_in_ready = in_ready;
    assign bus.data_out = out_q;
    assign bus.data_out_last = out_last_q;
    assign bus.data_out_valid = out_valid_q;
    assign bus.size_out = size_q;
    assign bus.size_err = err_q;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= S_EMPTY;
        else state_q <= state_d;
    end
    always_comb begin
        fin = (ok && d_eq_n) ? S_DRAIN : S_SIZE;
        state_d = acc ? (bus.data_in_last ? fin : S_HELD) :
                  (state_q == S_DRAIN && out_free) ? S_SIZE :
                  (state_q == S_SIZE && bus.size_ready) ? S_EMPTY : state_q;
    end
    // alive_q keeps data_in_ready low while reset is asserted
    always_comb begin
        in_ready = alive_q && (state_q == S_EMPTY || (state_q == S_HELD && out_free));
        bus.size_valid = state_q == S_SIZE;
    end
    always_comb begin
        h_d = h_q;
        out_d = out_q;
        out_last_d = out_last_q;
        out_valid_d = out_valid_q && !bus.data_out_ready;
        cnt_d = acc ? cnt_n : cnt_q;
        ovf_d = ovf_q || (acc && &cnt_q);
        size_d = size_q;
        err_d = err_q;
        if (acc && !bus.data_in_last) begin
            h_d = bus.data_in;
            if (state_q == S_HELD) begin
                out_d = h_q;
                out_last_d = 1'b0;
                out_valid_d = 1'b1;
            end
        end
        if (acc && bus.data_in_last) begin
            size_d = len;
            err_d = !ok;
            if (ok && d_eq_n) h_d = tail_blk;
            // D==N releases H ahead of F; D==N-1 makes H the final block (untrimmed when full)
            if (state_q == S_HELD && ok) begin
                out_d = (d_eq_n || r == '0) ? h_q : tail_blk;
                out_last_d = !d_eq_n;
                out_valid_d = 1'b1;
            end
        end
        if (state_q == S_DRAIN && out_free) begin
            out_d = h_q;
            out_last_d = 1'b1;
            out_valid_d = 1'b1;
        end
        if (state_q == S_SIZE && bus.size_ready) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            alive_q <= 1'b0;
            h_q <= '0;
            out_q <= '0;
            out_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            size_q <= '0;
            err_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            h_q <= h_d;
            out_q <= out_d;
            out_last_q <= out_last_d;
            out_valid_q <= out_valid_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            size_q <= size_d;
            err_q <= err_d;
        end
    end
endmodule
